// File: rtl/axi4lite_master_bresp_rx_if.sv
// rtl/axi4lite_master_bresp_rx_if.sv - AXI4-Lite write-response (B) channel signal bundle
interface axi4lite_master_bresp_rx_if;
    logic       BVALID;
    logic [1:0] BRESP;
    logic       BREADY;

    // Master receives the response and drives the ready
    modport master (
        input  BVALID,
        input  BRESP,
        output BREADY
    );

    // Slave drives the response and observes the ready
    modport slave (
        output BVALID,
        output BRESP,
        input  BREADY
    );
endinterface

// File: rtl/axi4lite_master_bresp_rx.sv
// rtl/axi4lite_master_bresp_rx.sv - master-side AXI4-Lite B-channel receiver with response FIFO and watchdog
module axi4lite_master_bresp_rx #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES  = 256,
    parameter int CNT_W           = 8,
    localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_issued,
    output logic                     issue_ready,
    axi4lite_master_bresp_rx_if.master b_if,
    output logic                     rsp_valid,
    output logic [1:0]               rsp_resp,
    input  logic                     rsp_ready,
    output logic [OUT_W-1:0]         outstanding,
    output logic                     timeout,
    output logic                     unexpected,
    output logic                     proto_err,
    output logic [CNT_W-1:0]         slverr_cnt,
    output logic [CNT_W-1:0]         decerr_cnt,
    input  logic                     err_clr
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_TOUT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;

    logic                rdy_q, rdy_d;
    logic [1:0]          mem_q [FIFO_DEPTH];
    logic [1:0]          mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic                timeout_q, timeout_d;
    logic                unexpected_q, unexpected_d;
    logic                proto_err_q, proto_err_d;
    logic [CNT_W-1:0]    slverr_q, slverr_d;
    logic [CNT_W-1:0]    decerr_q, decerr_d;

    logic fifo_full;
    logic fifo_empty;
    logic bready;
    logic hs;
    logic have_out;
    logic push;
    logic stray;
    logic issue_ok;
    logic issue_bad;
    logic pop;
    logic slv_ev;
    logic dec_ev;
    logic fire;

    // Handshake qualification; BREADY depends only on registered state, never on BVALID
    always_comb begin
        fifo_full   = (fcnt_q == FCNT_W'(FIFO_DEPTH));
        fifo_empty  = (fcnt_q == '0);
        bready      = rdy_q & ~fifo_full;
        hs          = b_if.BVALID & bready;
        have_out    = (out_q != '0);
        push        = hs & have_out;
        stray       = hs & ~have_out;
        issue_ready = (out_q < OUT_W'(MAX_OUTSTANDING));
        issue_ok    = wr_issued & issue_ready;
        issue_bad   = wr_issued & ~issue_ready;
        pop         = ~fifo_empty & rsp_ready;
        slv_ev      = push & (b_if.BRESP == 2'b10);
        dec_ev      = push & (b_if.BRESP == 2'b11);
    end

    assign b_if.BREADY = bready;
    assign rsp_valid   = ~fifo_empty;
    assign rsp_resp    = fifo_empty ? 2'b00 : mem_q[rd_ptr_q];
    assign outstanding = out_q;
    assign timeout     = timeout_q;
    assign unexpected  = unexpected_q;
    assign proto_err   = proto_err_q;
    assign slverr_cnt  = slverr_q;
    assign decerr_cnt  = decerr_q;

    // Response FIFO next state: write at tail on push, advance head on pop, occupancy tracks both
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = b_if.BRESP;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
            2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
            default: fcnt_d = fcnt_q;
        endcase
    end

    // In-flight count: accepted issue adds one, counted response removes one
    always_comb begin
        out_d = out_q;
        case ({issue_ok, push})
            2'b10:   out_d = out_q + OUT_W'(1);
            2'b01:   out_d = out_q - OUT_W'(1);
            default: out_d = out_q;
        endcase
    end

    // Watchdog FSM next state: counts quiet cycles while writes are outstanding
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        fire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tcnt_d = '0;
                if (out_d != '0) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (out_d == '0) begin
                    state_d = ST_IDLE;
                    tcnt_d  = '0;
                end else if (!hs && (tcnt_q == TCNT_LAST)) begin
                    fire    = 1'b1;
                    state_d = ST_TOUT;
                end else if (hs || err_clr) begin
                    tcnt_d = '0;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            ST_TOUT: begin
                if (err_clr) begin
                    tcnt_d  = '0;
                    state_d = (out_d == '0) ? ST_IDLE : ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tcnt_d  = '0;
            end
        endcase
    end

    // Sticky flags and saturating counters; a new event beats a coincident clear
    always_comb begin
        rdy_d        = 1'b1;
        timeout_d    = fire   | (timeout_q    & ~err_clr);
        unexpected_d = stray  | (unexpected_q & ~err_clr);
        proto_err_d  = issue_bad | (proto_err_q & ~err_clr);
        slverr_d     = slverr_q;
        decerr_d     = decerr_q;
        if (slv_ev) begin
            if (slverr_q != {CNT_W{1'b1}}) begin
                slverr_d = slverr_q + CNT_W'(1);
            end
        end else if (err_clr) begin
            slverr_d = '0;
        end
        if (dec_ev) begin
            if (decerr_q != {CNT_W{1'b1}}) begin
                decerr_d = decerr_q + CNT_W'(1);
            end
        end else if (err_clr) begin
            decerr_d = '0;
        end
    end

    // Watchdog FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Datapath registers: FIFO, in-flight count, flags and counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdy_q        <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fcnt_q       <= '0;
            out_q        <= '0;
            timeout_q    <= 1'b0;
            unexpected_q <= 1'b0;
            proto_err_q  <= 1'b0;
            slverr_q     <= '0;
            decerr_q     <= '0;
        end else begin
            rdy_q        <= rdy_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fcnt_q       <= fcnt_d;
            out_q        <= out_d;
            timeout_q    <= timeout_d;
            unexpected_q <= unexpected_d;
            proto_err_q  <= proto_err_d;
            slverr_q     <= slverr_d;
            decerr_q     <= decerr_d;
        end
    end

endmodule

// File: tb/tb_axi4lite_master_bresp_rx.sv
// tb/tb_axi4lite_master_bresp_rx.sv - self-checking bench for the AXI4-Lite B-channel receiver
module tb_axi4lite_master_bresp_rx;

    localparam int MO = 4;
    localparam int FD = 4;
    localparam int TO = 16;
    localparam int CW = 8;
    localparam int SAT = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       resetn;
    logic       wr_issued;
    logic       issue_ready;
    logic       rsp_valid;
    logic [1:0] rsp_resp;
    logic       rsp_ready;
    logic [2:0] outstanding;
    logic       timeout;
    logic       unexpected;
    logic       proto_err;
    logic [7:0] slverr_cnt;
    logic [7:0] decerr_cnt;
    logic       err_clr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi4lite_master_bresp_rx_if bif ();

    axi4lite_master_bresp_rx #(
        .MAX_OUTSTANDING(MO),
        .FIFO_DEPTH     (FD),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wr_issued  (wr_issued),
        .issue_ready(issue_ready),
        .b_if       (bif),
        .rsp_valid  (rsp_valid),
        .rsp_resp   (rsp_resp),
        .rsp_ready  (rsp_ready),
        .outstanding(outstanding),
        .timeout    (timeout),
        .unexpected (unexpected),
        .proto_err  (proto_err),
        .slverr_cnt (slverr_cnt),
        .decerr_cnt (decerr_cnt),
        .err_clr    (err_clr)
    );

    wire [26:0] dut_vec = {bif.BREADY, rsp_valid, rsp_resp, outstanding, issue_ready,
                           timeout, unexpected, proto_err, slverr_cnt, decerr_cnt};
    localparam logic [26:0] RESET_VEC = {1'b0, 1'b0, 2'b00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};

    // Reference model: a queue of responses, an in-flight count, a quiet-cycle count
    int         m_out, m_slv, m_dec, m_quiet;
    bit         m_rdy, m_to, m_unexp, m_perr, m_in_tout;
    logic [1:0] m_q[$];

    task automatic model_reset();
        m_out = 0; m_slv = 0; m_dec = 0; m_quiet = 0;
        m_rdy = 0; m_to = 0; m_unexp = 0; m_perr = 0; m_in_tout = 0;
        m_q.delete();
    endtask

    function automatic logic [26:0] model_vec();
        logic       b;
        logic [1:0] head;
        b    = m_rdy && (m_q.size() < FD);
        head = (m_q.size() > 0) ? m_q[0] : 2'b00;
        return {b, (m_q.size() > 0), head, 3'(m_out), (m_out < MO),
                m_to, m_unexp, m_perr, 8'(m_slv), 8'(m_dec)};
    endfunction

    task automatic model_step();
        bit hs, pushed, stray, iss, bad, pop, fire;
        hs     = bif.BVALID && m_rdy && (m_q.size() < FD);
        pushed = hs && (m_out > 0);
        stray  = hs && (m_out == 0);
        iss    = wr_issued && (m_out < MO);
        bad    = wr_issued && (m_out >= MO);
        pop    = (m_q.size() > 0) && rsp_ready;
        fire   = !m_in_tout && (m_out > 0) && !hs && (m_quiet == TO - 1);
        if (m_in_tout) begin
            if (err_clr) begin m_in_tout = 0; m_quiet = 0; end
        end else if (fire) begin
            m_in_tout = 1;
        end else if (m_out == 0 || hs || err_clr) begin
            m_quiet = 0;
        end else begin
            m_quiet++;
        end
        m_to    = fire  || (m_to    && !err_clr);
        m_unexp = stray || (m_unexp && !err_clr);
        m_perr  = bad   || (m_perr  && !err_clr);
        if (pushed && bif.BRESP == 2'b10) begin
            if (m_slv < SAT) m_slv++;
        end else if (err_clr) m_slv = 0;
        if (pushed && bif.BRESP == 2'b11) begin
            if (m_dec < SAT) m_dec++;
        end else if (err_clr) m_dec = 0;
        if (pop) void'(m_q.pop_front());
        if (pushed) m_q.push_back(bif.BRESP);
        m_out = m_out + int'(iss) - int'(pushed);
        m_rdy = 1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        wr_issued  = 1'b0;
        bif.BVALID = 1'b0;
        bif.BRESP  = 2'b00;
        rsp_ready  = 1'b0;
        err_clr    = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive_idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_vec !== RESET_VEC) begin
            failures++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec, RESET_VEC);
        end
        resetn = 1'b1;
        #1;
        checks++;
        if (bif.BREADY !== 1'b0) begin
            failures++; $display("FAIL reset_bready_before_edge got=%b exp=0", bif.BREADY);
        end
        tick();
        checks++;
        if (bif.BREADY !== 1'b1) begin
            failures++; $display("FAIL reset_bready_after_edge got=%b exp=1", bif.BREADY);
        end
    endtask

    task automatic test_in_order();
        logic [1:0] codes [3];
        codes = '{2'b00, 2'b10, 2'b11};
        wr_issued = 1'b1;
        repeat (3) tick();
        wr_issued = 1'b0;
        checks++;
        if (outstanding !== 3'd3) begin
            failures++; $display("FAIL order_outstanding3 got=%0d exp=3", outstanding);
        end
        for (int i = 0; i < 3; i++) begin
            bif.BVALID = 1'b1; bif.BRESP = codes[i];
            tick();
        end
        bif.BVALID = 1'b0;
        checks++;
        if ({slverr_cnt, decerr_cnt, outstanding} !== {8'd1, 8'd1, 3'd0}) begin
            failures++; $display("FAIL order_counts got=%0d/%0d/%0d exp=1/1/0", slverr_cnt, decerr_cnt, outstanding);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({rsp_valid, rsp_resp} !== {1'b1, codes[i]}) begin
                failures++; $display("FAIL order_head%0d got=%b/%b exp=1/%b", i, rsp_valid, rsp_resp, codes[i]);
            end
            tick();
        end
        rsp_ready = 1'b0;
        checks++;
        if (dut_vec !== model_vec()) begin
            failures++; $display("FAIL order_final got=%h exp=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] sent [5];
        rsp_ready = 1'b0;
        wr_issued = 1'b1;
        repeat (4) tick();
        wr_issued = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sent[i] = 2'($urandom_range(0, 3));
            bif.BVALID = 1'b1; bif.BRESP = sent[i];
            tick();
        end
        checks++;
        if ({bif.BREADY, rsp_valid, outstanding} !== {1'b0, 1'b1, 3'd0}) begin
            failures++; $display("FAIL bp_full got=%b/%b/%0d exp=0/1/0", bif.BREADY, rsp_valid, outstanding);
        end
        sent[4] = 2'($urandom_range(0, 3));
        bif.BRESP = sent[4];
        wr_issued = 1'b1;
        tick();
        wr_issued = 1'b0;
        repeat (2) tick();
        checks++;
        if ({bif.BREADY, outstanding} !== {1'b0, 3'd1}) begin
            failures++; $display("FAIL bp_held got=%b/%0d exp=0/1", bif.BREADY, outstanding);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (bif.BREADY !== 1'b1) begin
            failures++; $display("FAIL bp_reopen got=%b exp=1", bif.BREADY);
        end
        tick();
        bif.BVALID = 1'b0;
        checks++;
        if (dut_vec !== model_vec()) begin
            failures++; $display("FAIL bp_fifth got=%h exp=%h", dut_vec, model_vec());
        end
        rsp_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            checks++;
            if ({rsp_valid, rsp_resp} !== {1'b1, sent[i]}) begin
                failures++; $display("FAIL bp_drain%0d got=%b/%b exp=1/%b", i, rsp_valid, rsp_resp, sent[i]);
            end
            tick();
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++; $display("FAIL bp_empty got=%b exp=0", rsp_valid);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_unexpected();
        bif.BVALID = 1'b1; bif.BRESP = 2'b10;
        tick();
        bif.BVALID = 1'b0;
        checks++;
        if ({unexpected, rsp_valid} !== 2'b10) begin
            failures++; $display("FAIL unexp_set got=%b/%b exp=1/0", unexpected, rsp_valid);
        end
        checks++;
        if (dut_vec !== model_vec()) begin
            failures++; $display("FAIL unexp_state got=%h exp=%h", dut_vec, model_vec());
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if ({unexpected, slverr_cnt, decerr_cnt} !== {1'b0, 8'd0, 8'd0}) begin
            failures++; $display("FAIL unexp_clr got=%b/%0d/%0d exp=0/0/0", unexpected, slverr_cnt, decerr_cnt);
        end
    endtask

    task automatic test_timeout();
        wr_issued = 1'b1;
        tick();
        wr_issued = 1'b0;
        repeat (TO - 1) tick();
        checks++;
        if (timeout !== 1'b0) begin
            failures++; $display("FAIL to_early got=%b exp=0", timeout);
        end
        tick();
        checks++;
        if (timeout !== 1'b1) begin
            failures++; $display("FAIL to_fire got=%b exp=1", timeout);
        end
        repeat (3) tick();
        bif.BVALID = 1'b1; bif.BRESP = 2'b11;
        tick();
        bif.BVALID = 1'b0;
        checks++;
        if ({timeout, outstanding, rsp_valid, decerr_cnt} !== {1'b1, 3'd0, 1'b1, 8'd1}) begin
            failures++; $display("FAIL to_late_rsp got=%b/%0d/%b/%0d exp=1/0/1/1", timeout, outstanding, rsp_valid, decerr_cnt);
        end
        err_clr = 1'b1; rsp_ready = 1'b1;
        tick();
        err_clr = 1'b0; rsp_ready = 1'b0;
        repeat (TO + 4) tick();
        checks++;
        if (timeout !== 1'b0) begin
            failures++; $display("FAIL to_idle_quiet got=%b exp=0", timeout);
        end
        wr_issued = 1'b1;
        tick();
        wr_issued = 1'b0;
        repeat (TO - 1) tick();
        checks++;
        if (dut_vec !== model_vec()) begin
            failures++; $display("FAIL to_rearm got=%h exp=%h", dut_vec, model_vec());
        end
        bif.BVALID = 1'b1; bif.BRESP = 2'b00;
        tick();
        bif.BVALID = 1'b0; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_limits();
        rsp_ready = 1'b1;
        wr_issued = 1'b1;
        repeat (4) tick();
        checks++;
        if ({issue_ready, outstanding} !== {1'b0, 3'd4}) begin
            failures++; $display("FAIL lim_full got=%b/%0d exp=0/4", issue_ready, outstanding);
        end
        tick();
        wr_issued = 1'b0;
        checks++;
        if ({proto_err, outstanding} !== {1'b1, 3'd4}) begin
            failures++; $display("FAIL lim_proto got=%b/%0d exp=1/4", proto_err, outstanding);
        end
        err_clr = 1'b1; bif.BVALID = 1'b1; bif.BRESP = 2'b01;
        tick();
        err_clr = 1'b0;
        wr_issued = 1'b1;
        tick();
        wr_issued = 1'b0;
        checks++;
        if ({proto_err, outstanding} !== {1'b0, 3'd3}) begin
            failures++; $display("FAIL lim_same_cycle got=%b/%0d exp=0/3", proto_err, outstanding);
        end
        repeat (3) tick();
        bif.BVALID = 1'b0;
        checks++;
        if (dut_vec !== model_vec()) begin
            failures++; $display("FAIL lim_drained got=%h exp=%h", dut_vec, model_vec());
        end
        repeat (FD) tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_saturation();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        wr_issued = 1'b1;
        tick();
        bif.BVALID = 1'b1; bif.BRESP = 2'b10; rsp_ready = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 254) begin
                checks++;
                if (slverr_cnt !== 8'd254) begin
                    failures++; $display("FAIL sat_254 got=%0d exp=254", slverr_cnt);
                end
            end
        end
        wr_issued = 1'b0;
        tick();
        bif.BVALID = 1'b0;
        checks++;
        if ({slverr_cnt, decerr_cnt, outstanding} !== {8'd255, 8'd0, 3'd0}) begin
            failures++; $display("FAIL sat_255 got=%0d/%0d/%0d exp=255/0/0", slverr_cnt, decerr_cnt, outstanding);
        end
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 600; n++) begin
            wr_issued  = ($urandom_range(0, 2) == 0);
            bif.BVALID = ($urandom_range(0, 2) != 0);
            bif.BRESP  = 2'($urandom_range(0, 3));
            rsp_ready  = ($urandom_range(0, 3) != 0);
            err_clr    = ($urandom_range(0, 24) == 0);
            if (n >= 300 && n < 340) bif.BVALID = 1'b0;
            tick();
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                if (bad < 10) $display("FAIL random_cycle%0d got=%h exp=%h", n, dut_vec, model_vec());
                bad++;
            end
        end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        bif.BVALID = 1'b1; rsp_ready = 1'b1;
        repeat (MO + FD + 2) tick();
        drive_idle();
        wr_issued = 1'b1;
        repeat (3) tick();
        wr_issued = 1'b0; bif.BVALID = 1'b1; bif.BRESP = 2'b10;
        tick();
        bif.BVALID = 1'b0; bif.BRESP = 2'b00;
        checks++;
        if ({outstanding, rsp_valid} !== {3'd2, 1'b1}) begin
            failures++; $display("FAIL rmid_setup got=%0d/%b exp=2/1", outstanding, rsp_valid);
        end
        resetn = 1'b0;
        model_reset();
        #2;
        checks++;
        if (dut_vec !== RESET_VEC) begin
            failures++; $display("FAIL rmid_async got=%h exp=%h", dut_vec, RESET_VEC);
        end
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        tick();
        checks++;
        if (dut_vec !== model_vec()) begin
            failures++; $display("FAIL rmid_release got=%h exp=%h", dut_vec, model_vec());
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_backpressure();
        test_unexpected();
        test_timeout();
        test_limits();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit got=running exp=finished");
        $fatal(1, "time limit");
    end

endmodule
